// File: rtl/sfp_align_pkg.sv
// Shared types and constants for the 8b10b receive comma aligner.
// Optional lock-loss statistics are enabled with SFP_ALIGN_STATS_EN.
package sfp_align_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } align_state_t;

   localparam logic [7:0]  K28_5     = 8'hBC;
   localparam logic [31:0] IDLE_WORD = 32'h55a109bc;

   function automatic int sfp_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/sfp_comma_find.sv
// Priority encoder locating the lowest-index K-flagged comma byte in a GT word.
// Part of sfp_rx_word_align (optional stats macro: SFP_ALIGN_STATS_EN).
module sfp_comma_find
   import sfp_align_pkg::*;
#(
   parameter int         BYTES = 4,
   parameter logic [7:0] COMMA = K28_5,
   localparam int        POS_W = sfp_clog2(BYTES)
)(
   input  logic [8*BYTES-1:0] data,
   input  logic [BYTES-1:0]   charisk,
   output logic               hit,
   output logic [POS_W-1:0]   pos
);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      hit = 1'b0;
      pos = '0;
      // Scan downward so the lowest matching byte is the last one written.
      for (int k = BYTES - 1; k >= 0; k--) begin
         if (charisk[k] && (data[8*k +: 8] == COMMA)) begin
            hit = 1'b1;
            pos = POS_W'(k);
         end
      end
   end

endmodule

// File: rtl/sfp_rx_word_align.sv
// Receive comma aligner and lock monitor: rotates GT words so K28.5 lands in byte 0.
// Define SFP_ALIGN_STATS_EN to implement the lock_loss_cnt statistics counter.
module sfp_rx_word_align
   import sfp_align_pkg::*;
#(
   parameter int         BYTES    = 4,
   parameter logic [7:0] COMMA    = K28_5,
   parameter int         LOCK_CNT = 4,
   parameter int         LOSS_CNT = 8,
   localparam int        OFF_W    = sfp_clog2(BYTES)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_valid_in,
   input  logic [8*BYTES-1:0] rx_data_in,
   input  logic [BYTES-1:0]   rx_charisk_in,
   input  logic               rx_err_in,
   output logic [8*BYTES-1:0] rx_data_out,
   output logic [BYTES-1:0]   rx_charisk_out,
   output logic               rx_valid_out,
   output logic               locked,
   output logic [OFF_W-1:0]   align_offset,
   output logic [15:0]        lock_loss_cnt
);

   localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
   localparam logic [7:0] LOSS_LIM = 8'(LOSS_CNT);

   align_state_t         state;
   logic [OFF_W-1:0]     offset;
   logic [3:0]           cnt;
   logic [7:0]           err_cnt;
   logic                 locked_q;

   logic [8*BYTES-1:0]   prev_data;
   logic [BYTES-1:0]     prev_charisk;
   logic [8*BYTES-1:0]   data_q;
   logic [BYTES-1:0]     charisk_q;
   logic                 valid_q;

   logic                 hit;
   logic [OFF_W-1:0]     pos;
   logic [16*BYTES-1:0]  comb_data;
   logic [2*BYTES-1:0]   comb_charisk;
   logic [8*BYTES-1:0]   aligned_data;
   logic [BYTES-1:0]     aligned_charisk;

   logic [3:0]           cnt_inc;
   logic [7:0]           err_inc;
   logic                 lock_err;
   logic                 loss_evt;

   sfp_comma_find #(
      .BYTES   (BYTES),
      .COMMA   (COMMA)
   ) u_comma_find (
      .data    (rx_data_in),
      .charisk (rx_charisk_in),
      .hit     (hit),
      .pos     (pos)
   );

   // The previous word occupies the low half so offset selects forward across the boundary.
   assign comb_data    = {rx_data_in, prev_data};
   assign comb_charisk = {rx_charisk_in, prev_charisk};

   always_comb begin
      aligned_data    = '0;
      aligned_charisk = '0;
      for (int k = 0; k < BYTES; k++) begin
         aligned_data[8*k +: 8] = comb_data[8*(int'(offset) + k) +: 8];
         aligned_charisk[k]     = comb_charisk[int'(offset) + k];
      end
   end

   assign cnt_inc  = cnt + 4'd1;
   assign err_inc  = err_cnt + 8'd1;
   assign lock_err = rx_err_in | (hit & (pos != offset));
   assign loss_evt = rx_valid_in & (state == LOCKED) & lock_err & (err_inc == LOSS_LIM);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         // NOTE: the datapath registers are reset as well so no stale word leaks out after reset.
         prev_data    <= '0;
         prev_charisk <= '0;
         data_q       <= '0;
         charisk_q    <= '0;
         valid_q      <= 1'b0;
      end else begin
         valid_q <= rx_valid_in;
         if (rx_valid_in) begin
            prev_data    <= rx_data_in;
            prev_charisk <= rx_charisk_in;
            data_q       <= aligned_data;
            charisk_q    <= aligned_charisk;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= SEARCH;
         offset   <= '0;
         cnt      <= '0;
         err_cnt  <= '0;
         locked_q <= 1'b0;
      end else if (rx_valid_in) begin
         unique case (state)
            SEARCH: begin
               if (hit) begin
                  offset  <= pos;
                  cnt     <= 4'd1;
                  err_cnt <= '0;
                  if (LOCK_LIM == 4'd1) begin
                     state    <= LOCKED;
                     locked_q <= 1'b1;
                  end else begin
                     state <= CHECK;
                  end
               end
            end
            CHECK: begin
               if (rx_err_in) begin
                  state <= SEARCH;
                  cnt   <= '0;
               end else if (hit) begin
                  if (pos == offset) begin
                     cnt <= cnt_inc;
                     if (cnt_inc == LOCK_LIM) begin
                        state    <= LOCKED;
                        locked_q <= 1'b1;
                        err_cnt  <= '0;
                     end
                  end else begin
                     offset <= pos;
                     cnt    <= 4'd1;
                  end
               end
            end
            LOCKED: begin
               // Offset is frozen here; it only moves again on the next SEARCH hit.
               if (loss_evt) begin
                  state    <= SEARCH;
                  locked_q <= 1'b0;
                  cnt      <= '0;
                  err_cnt  <= '0;
               end else if (lock_err) begin
                  err_cnt <= err_inc;
               end else if (hit) begin
                  err_cnt <= '0;
               end
            end
            default: begin
               state    <= SEARCH;
               locked_q <= 1'b0;
               cnt      <= '0;
               err_cnt  <= '0;
            end
         endcase
      end
   end

`ifdef SFP_ALIGN_STATS_EN
   logic [15:0] loss_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         loss_q <= '0;
      end else if (loss_evt && (loss_q != 16'hFFFF)) begin
         loss_q <= loss_q + 16'd1;
      end
   end

   assign lock_loss_cnt = loss_q;
`else
   assign lock_loss_cnt = '0;
`endif

   assign rx_data_out    = data_q;
   assign rx_charisk_out = charisk_q;
   assign rx_valid_out   = valid_q & locked_q;
   assign locked         = locked_q;
   assign align_offset   = offset;

endmodule

// File: tb/tb_sfp_rx_word_align.sv
// Directed self-checking bench for sfp_rx_word_align (BYTES=4, LOCK_CNT=4, LOSS_CNT=8).
// Expected lock_loss_cnt follows SFP_ALIGN_STATS_EN.
module tb_sfp_rx_word_align;
   import sfp_align_pkg::*;

`ifdef SFP_ALIGN_STATS_EN
   localparam logic [15:0] EXP_LOSS = 16'd1;
`else
   localparam logic [15:0] EXP_LOSS = 16'd0;
`endif

   localparam logic [31:0] ROT_WORD  = 32'h09bc55a1;
   localparam logic [31:0] BYTE1_WRD = 32'ha109bc55;

   logic        clk;
   logic        rst;
   logic        rx_valid_in;
   logic [31:0] rx_data_in;
   logic [3:0]  rx_charisk_in;
   logic        rx_err_in;
   logic [31:0] rx_data_out;
   logic [3:0]  rx_charisk_out;
   logic        rx_valid_out;
   logic        locked;
   logic [1:0]  align_offset;
   logic [15:0] lock_loss_cnt;

   int n_tests;
   int n_fail;

   sfp_rx_word_align #(
      .BYTES    (4),
      .COMMA    (8'hBC),
      .LOCK_CNT (4),
      .LOSS_CNT (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_valid_in    (rx_valid_in),
      .rx_data_in     (rx_data_in),
      .rx_charisk_in  (rx_charisk_in),
      .rx_err_in      (rx_err_in),
      .rx_data_out    (rx_data_out),
      .rx_charisk_out (rx_charisk_out),
      .rx_valid_out   (rx_valid_out),
      .locked         (locked),
      .align_offset   (align_offset),
      .lock_loss_cnt  (lock_loss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " data"},   rx_data_out,    32'h0);
      check({tag, " k"},      32'(rx_charisk_out), 32'h0);
      check({tag, " valid"},  32'(rx_valid_out),   32'h0);
      check({tag, " locked"}, 32'(locked),         32'h0);
      check({tag, " offset"}, 32'(align_offset),   32'h0);
      check({tag, " loss"},   32'(lock_loss_cnt),  32'h0);
   endtask

   // Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
   task automatic send(input logic [31:0] d, input logic [3:0] k, input logic err);
      rx_valid_in   = 1'b1;
      rx_data_in    = d;
      rx_charisk_in = k;
      rx_err_in     = err;
      @(posedge clk);
      #1;
      rx_valid_in   = 1'b0;
   endtask

   task automatic bubble();
      rx_valid_in   = 1'b0;
      rx_data_in    = $urandom;
      rx_charisk_in = 4'($urandom);
      rx_err_in     = 1'($urandom);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         rx_valid_in   = 1'b1;
         rx_data_in    = $urandom;
         rx_charisk_in = 4'($urandom);
         rx_err_in     = 1'($urandom);
         @(posedge clk);
         #1;
      end
      rst         = 1'b0;
      rx_valid_in = 1'b0;
   endtask

   task automatic send_idle(input int n);
      for (int i = 0; i < n; i++) send(IDLE_WORD, 4'b0001, 1'b0);
   endtask

   logic [31:0] gap_word [1:8];

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst           = 1'b1;
      rx_valid_in   = 1'b0;
      rx_data_in    = '0;
      rx_charisk_in = '0;
      rx_err_in     = 1'b0;

      // Reset with random traffic, then commas without their K flag must not count.
      do_reset(3);
      check_zero("reset");
      for (int i = 0; i < 4; i++) send(IDLE_WORD, 4'b0000, 1'b0);
      check("no_k locked", 32'(locked), 32'h0);
      check("no_k valid",  32'(rx_valid_out), 32'h0);

      // Aligned idle stream locks after the 4th word.
      do_reset(1);
      send_idle(3);
      check("idle w3 locked", 32'(locked), 32'h0);
      send_idle(1);
      check("idle w4 locked", 32'(locked), 32'h1);
      check("idle valid",     32'(rx_valid_out), 32'h1);
      check("idle data",      rx_data_out, 32'h55a109bc);
      check("idle k",         32'(rx_charisk_out), 32'h1);
      check("idle offset",    32'(align_offset), 32'h0);

      // Rotated stream: comma in byte 2.
      do_reset(1);
      for (int i = 0; i < 3; i++) send(ROT_WORD, 4'b0100, 1'b0);
      check("rot w3 locked", 32'(locked), 32'h0);
      send(ROT_WORD, 4'b0100, 1'b0);
      check("rot locked", 32'(locked), 32'h1);
      check("rot offset", 32'(align_offset), 32'h2);
      check("rot data",   rx_data_out, 32'h55a109bc);
      check("rot k",      32'(rx_charisk_out), 32'h1);
      check("rot valid",  32'(rx_valid_out), 32'h1);

      // Two commas per word: the lower index (byte 1) wins.
      do_reset(1);
      for (int i = 0; i < 4; i++) send(32'hbc00bc00, 4'b1010, 1'b0);
      check("multi offset", 32'(align_offset), 32'h1);
      check("multi locked", 32'(locked), 32'h1);
      check("multi data",   rx_data_out, 32'h00bc00bc);
      check("multi k",      32'(rx_charisk_out), 32'h5);

      // Offset change during CHECK restarts the count.
      do_reset(1);
      send_idle(2);
      for (int i = 0; i < 3; i++) send(BYTE1_WRD, 4'b0010, 1'b0);
      check("chg w5 locked", 32'(locked), 32'h0);
      check("chg w5 offset", 32'(align_offset), 32'h1);
      send(BYTE1_WRD, 4'b0010, 1'b0);
      check("chg w6 locked", 32'(locked), 32'h1);
      check("chg offset",    32'(align_offset), 32'h1);
      check("chg data",      rx_data_out, 32'h55a109bc);
      check("chg k",         32'(rx_charisk_out), 32'h1);

      // Loss of sync: a clean comma clears the error count; 8 in a row drop lock.
      do_reset(1);
      for (int i = 0; i < 4; i++) send(ROT_WORD, 4'b0100, 1'b0);
      for (int i = 0; i < 7; i++) send(ROT_WORD, 4'b0100, 1'b1);
      send(ROT_WORD, 4'b0100, 1'b0);
      for (int i = 0; i < 7; i++) send(ROT_WORD, 4'b0100, 1'b1);
      check("loss 7 locked", 32'(locked), 32'h1);
      check("loss 7 loss",   32'(lock_loss_cnt), 32'h0);
      send(ROT_WORD, 4'b0100, 1'b1);
      check("loss 8 locked", 32'(locked), 32'h0);
      check("loss 8 valid",  32'(rx_valid_out), 32'h0);
      check("loss 8 count",  32'(lock_loss_cnt), 32'(EXP_LOSS));
      check("loss offset held", 32'(align_offset), 32'h2);
      send_idle(3);
      check("relock w3 locked", 32'(locked), 32'h0);
      send_idle(1);
      check("relock locked", 32'(locked), 32'h1);
      check("relock offset", 32'(align_offset), 32'h0);
      check("relock data",   rx_data_out, 32'h55a109bc);
      check("relock count",  32'(lock_loss_cnt), 32'(EXP_LOSS));

      // Bubbles between valid words: output sequence is the previous valid word.
      do_reset(1);
      for (int i = 1; i <= 8; i++)
         gap_word[i] = {8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i), 8'hbc};
      for (int i = 1; i <= 8; i++) begin
         send(gap_word[i], 4'b0001, 1'b0);
         check($sformatf("gap w%0d locked", i), 32'(locked), 32'(i >= 4));
         if (i >= 4) begin
            check($sformatf("gap w%0d data", i),  rx_data_out, gap_word[i-1]);
            check($sformatf("gap w%0d valid", i), 32'(rx_valid_out), 32'h1);
         end
         if (i % 2 == 0) begin
            bubble();
            check($sformatf("gap b%0d valid", i),  32'(rx_valid_out), 32'h0);
            check($sformatf("gap b%0d locked", i), 32'(locked), 32'(i >= 4));
            if (i >= 4) check($sformatf("gap b%0d hold", i), rx_data_out, gap_word[i-1]);
         end
      end

      // Reset mid-stream clears everything on the next cycle.
      do_reset(1);
      check_zero("midrst");
      send_idle(1);
      check("midrst w1 locked", 32'(locked), 32'h0);
      check("midrst w1 valid",  32'(rx_valid_out), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
